latch_mapper: RTL and testbench

//  Parametrised successor of the unlicensed/misc cart mapper. Handles Wisdom Tree
//  (mode 0), Mani DMG-601 (mode 1) and a multicart outer/inner 16KB mapper with
//  RAM banking and a lock sequence (mode 2). Sits on the shared mapper bus and

---
 rtl/latch_mapper.sv | 151 +++++++++++++++
 tb/tb_latch_mapper.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_mapper.sv
// Latch-style unlicensed cart mapper: Wisdom Tree, Mani DMG-601 and a lockable
// outer/inner multicart. Every mode shares one register set; the mode only changes decode.
module latch_mapper #(
  parameter int ROM_BANK_W = 8,
  parameter int OUTER_W    = 3,
  parameter int RAM_BANK_W = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce_cpu,
  input  logic [1:0]  mapper_sel,
  input  logic        savestate_load,
  input  logic [15:0] savestate_data,
  inout  wire  [15:0] savestate_back_b,
  input  logic [8:0]  rom_mask,
  input  logic [14:0] cart_addr,
  input  logic        cart_a15,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  input  logic [7:0]  cram_di,
  inout  wire  [7:0]  cram_do_b,
  inout  wire  [16:0] cram_addr_b,
  inout  wire  [22:0] mbc_addr_b,
  inout  wire         ram_enabled_b,
  inout  wire         has_battery_b
);
  localparam int INNER_W = ROM_BANK_W - OUTER_W;
  localparam logic [1:0] M_WT    = 2'd0;
  localparam logic [1:0] M_DMG   = 2'd1;
  localparam logic [1:0] M_MULTI = 2'd2;

  typedef enum logic [1:0] {UNLOCKED = 2'd0, ARMED = 2'd1, LOCKED = 2'd2} lock_e;

  logic [ROM_BANK_W-1:0] r_rom_bank,  w_rom_bank_nxt;
  logic [OUTER_W-1:0]    r_outer,     w_outer_nxt;
  lock_e                 r_lock_st,   w_lock_nxt;
  logic                  r_ram_en,    w_ram_en_nxt;
  logic [RAM_BANK_W-1:0] r_ram_bank,  w_ram_bank_nxt;

  logic [1:0]            w_mode;
  logic                  w_wr;
  logic [INNER_W-1:0]    w_inner_wr;
  logic [INNER_W-1:0]    w_inner_field;
  logic [ROM_BANK_W-1:0] w_bank_raw;
  logic [7:0]            w_bank;
  logic [22:0]           w_mbc_addr;
  logic [16:0]           w_cram_addr;
  logic [7:0]            w_cram_do;
  logic                  w_ram_on;
  logic [15:0]           w_ss_back;
  logic                  w_unused_mask;

  assign w_mode        = (mapper_sel == 2'd3) ? M_WT : mapper_sel;
  assign w_wr          = ce_cpu & cart_wr & ~cart_a15;
  assign w_inner_wr    = (cart_di[INNER_W-1:0] == '0) ? INNER_W'(1) : cart_di[INNER_W-1:0];
  assign w_unused_mask = rom_mask[0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_bank <= '0;
      r_outer    <= '0;
      r_lock_st  <= UNLOCKED;
      r_ram_en   <= 1'b0;
      r_ram_bank <= '0;
    end else begin
      r_rom_bank <= w_rom_bank_nxt;
      r_outer    <= w_outer_nxt;
      r_lock_st  <= w_lock_nxt;
      r_ram_en   <= w_ram_en_nxt;
      r_ram_bank <= w_ram_bank_nxt;
    end
  end

  // DMG-601 keeps its one-shot flag in lock_st[0] so it survives a savestate.
  always_comb begin
    w_rom_bank_nxt = r_rom_bank;
    w_outer_nxt    = r_outer;
    w_lock_nxt     = r_lock_st;
    w_ram_en_nxt   = r_ram_en;
    w_ram_bank_nxt = r_ram_bank;
    if (savestate_load && enable) begin
      w_rom_bank_nxt = savestate_data[ROM_BANK_W-1:0];
      w_outer_nxt    = savestate_data[8 +: OUTER_W];
      w_lock_nxt     = lock_e'(savestate_data[12:11]);
      w_ram_en_nxt   = savestate_data[13];
      w_ram_bank_nxt = savestate_data[14 +: RAM_BANK_W];
    end else if (!enable) begin
      w_rom_bank_nxt = '0;
      w_outer_nxt    = '0;
      w_lock_nxt     = UNLOCKED;
      w_ram_en_nxt   = 1'b0;
      w_ram_bank_nxt = '0;
    end else if (w_wr) begin
      case (w_mode)
        M_DMG: begin
          if (!r_lock_st[0]) begin
            w_rom_bank_nxt = ROM_BANK_W'(cart_di[2:0]);
            w_lock_nxt     = lock_e'({r_lock_st[1], 1'b1});
          end
        end
        M_MULTI: begin
          case (cart_addr[14:13])
            2'b00: w_ram_en_nxt   = (cart_di[3:0] == 4'hA);
            2'b01: w_rom_bank_nxt = ROM_BANK_W'(w_inner_wr);
            2'b10: w_ram_bank_nxt = cart_di[RAM_BANK_W-1:0];
            default: begin
              case (r_lock_st)
                UNLOCKED: begin
                  if (cart_di == 8'h5A) w_lock_nxt  = ARMED;
                  else                  w_outer_nxt = cart_di[OUTER_W-1:0];
                end
                ARMED:   w_lock_nxt = (cart_di == 8'hA5) ? LOCKED : UNLOCKED;
                default: ;
              endcase
            end
          endcase
        end
        default: w_rom_bank_nxt = cart_addr[ROM_BANK_W-1:0];
      endcase
    end
  end

  // Multicart low half (A14=0) always sees inner bank 0 of the selected game.
  assign w_inner_field = cart_addr[14] ? r_rom_bank[INNER_W-1:0] : '0;
  assign w_bank_raw    = (w_mode == M_MULTI) ? {r_outer, w_inner_field} : r_rom_bank;
  assign w_bank        = 8'(w_bank_raw) & rom_mask[8:1];
  assign w_mbc_addr    = (w_mode == M_MULTI) ? {1'b0, w_bank, cart_addr[13:0]}
                                             : {w_bank, cart_addr[14:0]};
  assign w_ram_on      = (w_mode == M_MULTI) & r_ram_en;
  assign w_cram_addr   = (w_mode == M_MULTI) ? {4'(r_ram_bank), cart_addr[12:0]}
                                             : {4'b0, cart_addr[12:0]};
  assign w_cram_do     = w_ram_on ? cram_di : 8'hFF;

  always_comb begin
    w_ss_back                     = '0;
    w_ss_back[ROM_BANK_W-1:0]     = r_rom_bank;
    w_ss_back[8 +: OUTER_W]       = r_outer;
    w_ss_back[12:11]              = r_lock_st;
    w_ss_back[13]                 = r_ram_en;
    w_ss_back[14 +: RAM_BANK_W]   = r_ram_bank;
  end

  assign savestate_back_b = enable ? w_ss_back   : 'z;
  assign cram_do_b        = enable ? w_cram_do   : 'z;
  assign cram_addr_b      = enable ? w_cram_addr : 'z;
  assign mbc_addr_b       = enable ? w_mbc_addr  : 'z;
  assign ram_enabled_b    = enable ? w_ram_on    : 1'bz;
  assign has_battery_b    = enable ? 1'b0        : 1'bz;

endmodule

// File: tb/tb_latch_mapper.sv
// Scoreboarded bench for latch_mapper: stimulus pushes reference-model results,
// a negedge monitor pops them whenever a probe is presented.
`timescale 1ns/1ps
module tb_latch_mapper;
  logic        clk_sys = 1'b0;
  logic        reset_n, enable, ce_cpu, savestate_load, cart_a15, cart_wr;
  logic [1:0]  mapper_sel;
  logic [15:0] savestate_data;
  logic [8:0]  rom_mask;
  logic [14:0] cart_addr;
  logic [7:0]  cart_di, cram_di;
  wire  [15:0] savestate_back_b;
  wire  [7:0]  cram_do_b;
  wire  [16:0] cram_addr_b;
  wire  [22:0] mbc_addr_b;
  wire         ram_enabled_b, has_battery_b;

  latch_mapper dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .ce_cpu(ce_cpu),
    .mapper_sel(mapper_sel), .savestate_load(savestate_load),
    .savestate_data(savestate_data), .savestate_back_b(savestate_back_b),
    .rom_mask(rom_mask), .cart_addr(cart_addr), .cart_a15(cart_a15),
    .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
    .cram_do_b(cram_do_b), .cram_addr_b(cram_addr_b), .mbc_addr_b(mbc_addr_b),
    .ram_enabled_b(ram_enabled_b), .has_battery_b(has_battery_b)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [22:0] mbc;
    logic [16:0] cram_addr;
    logic [7:0]  cram_do;
    logic        ram_en;
    logic [15:0] ss;
    string       tag;
  } exp_t;

  exp_t q[$];
  logic probe_vld = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference state, plain integers
  int m_sel, m_bank, m_outer, m_lock, m_ram_en, m_ram_bank;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  function automatic void model_clear();
    m_bank = 0; m_outer = 0; m_lock = 0; m_ram_en = 0; m_ram_bank = 0;
  endfunction

  function automatic int model_img();
    return m_bank + m_outer * 256 + m_lock * 2048 + m_ram_en * 8192 + m_ram_bank * 16384;
  endfunction

  function automatic void model_load(int d);
    m_bank = d % 256; m_outer = (d / 256) % 8; m_lock = (d / 2048) % 4;
    m_ram_en = (d / 8192) % 2; m_ram_bank = (d / 16384) % 4;
  endfunction

  function automatic void model_write(logic a15, logic ce, int a, int d);
    int mode;
    if (a15 || !ce) return;
    mode = (m_sel == 3) ? 0 : m_sel;
    if (mode == 0) m_bank = a % 256;
    else if (mode == 1) begin
      if (m_lock % 2 == 0) begin
        m_bank = d % 8;
        m_lock = m_lock + 1;
      end
    end else begin
      case ((a / 8192) % 4)
        0: m_ram_en = (d % 16 == 10) ? 1 : 0;
        1: m_bank = (d % 32 == 0) ? 1 : d % 32;
        2: m_ram_bank = d % 4;
        default: begin
          if (m_lock == 0) begin
            if (d == 'h5A) m_lock = 1;
            else m_outer = d % 8;
          end else if (m_lock == 1) m_lock = (d == 'hA5) ? 2 : 0;
        end
      endcase
    end
  endfunction

  function automatic exp_t model_out(int a, int cd, string tag);
    exp_t e;
    int mode, mask, bank;
    mode = (m_sel == 3) ? 0 : m_sel;
    mask = int'(rom_mask) / 2;
    if (mode == 2) begin
      bank = m_outer * 32 + ((a >= 16384) ? m_bank % 32 : 0);
      bank = bank & mask;
      e.mbc = 23'(bank * 16384 + a % 16384);
      e.ram_en = (m_ram_en != 0);
      e.cram_addr = 17'(m_ram_bank * 8192 + a % 8192);
      e.cram_do = (m_ram_en != 0) ? 8'(cd) : 8'hFF;
    end else begin
      bank = m_bank & mask;
      e.mbc = 23'(bank * 32768 + a);
      e.ram_en = 1'b0;
      e.cram_addr = 17'(a % 8192);
      e.cram_do = 8'hFF;
    end
    e.ss = 16'(model_img());
    e.tag = tag;
    return e;
  endfunction

  always @(negedge clk_sys) begin
    if (probe_vld) begin
      if (q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".mbc"},   32'(mbc_addr_b),    32'(e.mbc));
        chk({e.tag, ".caddr"}, 32'(cram_addr_b),   32'(e.cram_addr));
        chk({e.tag, ".cdo"},   32'(cram_do_b),     32'(e.cram_do));
        chk({e.tag, ".ramen"}, 32'(ram_enabled_b), 32'(e.ram_en));
        chk({e.tag, ".ss"},    32'(savestate_back_b), 32'(e.ss));
        chk({e.tag, ".batt"},  32'(has_battery_b), 32'd0);
      end
    end
  end

  task automatic wr(input logic a15, input logic [14:0] a, input logic [7:0] d,
                    input logic ce = 1'b1);
    @(posedge clk_sys); #1;
    cart_a15 = a15; cart_addr = a; cart_di = d; cart_wr = 1'b1; ce_cpu = ce;
    @(posedge clk_sys); #1;
    cart_wr = 1'b0; ce_cpu = 1'b0; cart_a15 = 1'b0;
    model_write(a15, ce, int'(a), int'(d));
  endtask

  task automatic probe(input logic [14:0] a, input string tag);
    @(posedge clk_sys); #1;
    cart_addr = a;
    cram_di = 8'($urandom);
    q.push_back(model_out(int'(a), int'(cram_di), tag));
    probe_vld = 1'b1;
    @(negedge clk_sys); #1;
    probe_vld = 1'b0;
  endtask

  task automatic set_mode(input int s);
    @(posedge clk_sys); #1;
    mapper_sel = 2'(s); m_sel = s;
  endtask

  task automatic en_pulse();
    @(posedge clk_sys); #1 enable = 1'b0;
    @(posedge clk_sys); #1 enable = 1'b1;
    model_clear();
  endtask

  task automatic ss_load(input logic [15:0] d);
    @(posedge clk_sys); #1;
    savestate_load = 1'b1; savestate_data = d;
    @(posedge clk_sys); #1;
    savestate_load = 1'b0;
    model_load(int'(d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int img;
    reset_n = 1'b0; enable = 1'b1; ce_cpu = 1'b0; savestate_load = 1'b0;
    cart_a15 = 1'b0; cart_wr = 1'b0; mapper_sel = 2'd0; savestate_data = '0;
    rom_mask = 9'h1FF; cart_addr = '0; cart_di = '0; cram_di = '0;
    m_sel = 0; model_clear();
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    probe(15'h1234, "reset");

    // Wisdom Tree, with and without ROM mask mirroring
    wr(1'b0, 15'h0013, 8'h00);
    probe(15'h4000, "t1");
    rom_mask = 9'h00F;
    probe(15'h4000, "t1_mask");
    rom_mask = 9'h1FF;

    // DMG-601 one-shot
    set_mode(1); en_pulse();
    wr(1'b0, 15'h2000, 8'h05);
    wr(1'b0, 15'h2000, 8'h02);
    probe(15'h4000, "t2_once");
    en_pulse();
    probe(15'h4000, "t2_clr");
    wr(1'b0, 15'h2000, 8'h02);
    probe(15'h4000, "t2_again");

    // Multicart banking
    set_mode(2); en_pulse();
    wr(1'b0, 15'h6000, 8'h03);
    wr(1'b0, 15'h2000, 8'h00);
    probe(15'h4000, "t3_hi");
    probe(15'h0000, "t3_lo");

    // Lock sequence, then a broken sequence
    wr(1'b0, 15'h7000, 8'h5A);
    wr(1'b0, 15'h7000, 8'hA5);
    wr(1'b0, 15'h7000, 8'h01);
    probe(15'h0000, "t4_locked");
    en_pulse();
    wr(1'b0, 15'h6000, 8'h05);
    wr(1'b0, 15'h7000, 8'h5A);
    wr(1'b0, 15'h7000, 8'h11);
    wr(1'b0, 15'h7000, 8'hA5);
    probe(15'h4000, "t4_broken");

    // RAM enable/banking, plus writes that must not land
    wr(1'b0, 15'h0000, 8'h0A);
    wr(1'b0, 15'h4000, 8'h02);
    probe(15'h2000, "t5_ram");
    wr(1'b1, 15'h4000, 8'h01);
    wr(1'b0, 15'h4000, 8'h03, 1'b0);
    probe(15'h3FFF, "t5_nowr");
    wr(1'b0, 15'h0000, 8'h00);
    probe(15'h2000, "t5_off");

    // Async reset during a live write
    wr(1'b0, 15'h0000, 8'h0A);
    @(posedge clk_sys); #1;
    cart_addr = 15'h4000; cart_di = 8'h03; cart_wr = 1'b1; ce_cpu = 1'b1; reset_n = 1'b0;
    model_clear();
    probe(15'h4000, "t6_reset");
    @(posedge clk_sys); #1;
    cart_wr = 1'b0; ce_cpu = 1'b0; reset_n = 1'b1;

    // Savestate round trip
    wr(1'b0, 15'h6000, 8'h06);
    wr(1'b0, 15'h2000, 8'h13);
    wr(1'b0, 15'h0000, 8'h0A);
    wr(1'b0, 15'h4000, 8'h03);
    wr(1'b0, 15'h7000, 8'h5A);
    img = model_img();
    en_pulse();
    probe(15'h4000, "t6_cleared");
    ss_load(16'(img));
    probe(15'h5555, "t6_restore");

    // Mode reinterpretation
    set_mode(0); probe(15'h4321, "sel0");
    set_mode(3); probe(15'h7FFF, "sel3");
    set_mode(2);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) set_mode($urandom_range(0, 3));
      else if (r < 8) en_pulse();
      else if (r < 12) ss_load(16'($urandom));
      else if (r < 15) rom_mask = 9'($urandom);
      else if (r < 60) begin
        logic [7:0] d;
        case ($urandom_range(0, 3))
          0: d = 8'h5A;
          1: d = 8'hA5;
          2: d = 8'h0A;
          default: d = 8'($urandom);
        endcase
        wr(($urandom_range(0, 7) == 0), 15'($urandom), d, ($urandom_range(0, 7) != 0));
      end else probe(15'($urandom), "rnd");
    end

    repeat (3) @(posedge clk_sys);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
